// File: rtl/final_project_soc_mem_tester_pkg.sv
// rtl/final_project_soc_mem_tester_pkg.sv - shared state type, constants and pattern helpers for the memory tester
package final_project_soc_mem_tester_pkg;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] MULT      = 32'h0101_0101;

    function automatic logic [31:0] pattern_fn(input logic [31:0] seed, input logic [31:0] addr);
        return seed ^ (addr * MULT);
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ LFSR_TAPS) : (x >> 1);
    endfunction

endpackage

// File: rtl/final_project_soc_mem_tester_patgen.sv
// rtl/final_project_soc_mem_tester_patgen.sv - test pattern source; FINAL_PROJECT_SOC_MEM_TESTER_LFSR_EN selects Galois LFSR over address-XOR
module final_project_soc_mem_tester_patgen
    import final_project_soc_mem_tester_pkg::*;
#(
    parameter int          ADDR_W = 2,
    parameter logic [31:0] SEED   = 32'hA5A5_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              advance,
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       pattern
);

`ifdef FINAL_PROJECT_SOC_MEM_TESTER_LFSR_EN
    localparam logic [31:0] INIT = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] lfsr_q;
    logic [31:0] cur;
    logic        unused_addr;

    // restart supplies word 0 of a phase directly so the first issue needs no bubble
    assign cur         = restart ? INIT : lfsr_q;
    assign pattern     = cur;
    assign unused_addr = ^addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= INIT;
        end else if (advance) begin
            lfsr_q <= lfsr_step(cur);
        end
    end
`else
    logic unused_ctl;

    assign pattern    = pattern_fn(SEED, 32'(addr));
    assign unused_ctl = ^{clk, reset, restart, advance};
`endif

endmodule

// File: rtl/final_project_soc_onchip_mem_tester.sv
// rtl/final_project_soc_onchip_mem_tester.sv - write/readback self-test initiator for on-chip memory; option FINAL_PROJECT_SOC_MEM_TESTER_LFSR_EN
module final_project_soc_onchip_mem_tester
    import final_project_soc_mem_tester_pkg::*;
#(
    parameter int          ADDR_W       = 2,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] SEED         = 32'hA5A5_0000,
    parameter int          ERR_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic              avm_clken,
    input  logic [31:0]       avm_readdata
);

    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    state_t              state, state_next;
    logic                issue, issue_wr, restart, clear;
    logic [ADDR_W-1:0]   addr_next;
    logic [31:0]         pattern;
    logic [31:0]         exp_q;
    logic                cmp_miss;

    logic [READ_LATENCY-1:0] sr_valid;
    logic [31:0]             sr_exp  [READ_LATENCY];
    logic [ADDR_W-1:0]       sr_addr [READ_LATENCY];

    final_project_soc_mem_tester_patgen #(
        .ADDR_W (ADDR_W),
        .SEED   (SEED)
    ) u_patgen (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .advance (issue),
        .addr    (addr_next),
        .pattern (pattern)
    );

    assign avm_byteenable = 4'hF;
    assign avm_clken      = 1'b1;
    assign busy           = (state == WRITE) || (state == READ) || (state == DRAIN);
    assign done           = (state == DONE);
    assign pass           = done && (err_count == '0);
    assign cmp_miss       = sr_valid[READ_LATENCY-1] && (avm_readdata != sr_exp[READ_LATENCY-1]);

    // The registered bus address doubles as the phase address counter.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        issue_wr   = 1'b0;
        restart    = 1'b0;
        clear      = 1'b0;
        addr_next  = '0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = WRITE;
                    issue      = 1'b1;
                    issue_wr   = 1'b1;
                    restart    = 1'b1;
                    clear      = 1'b1;
                end
            end
            WRITE: begin
                issue = 1'b1;
                if (avm_address == LAST) begin
                    state_next = READ;
                    restart    = 1'b1;
                end else begin
                    issue_wr  = 1'b1;
                    addr_next = avm_address + 1'b1;
                end
            end
            READ: begin
                if (avm_address == LAST) begin
                    state_next = DRAIN;
                end else begin
                    issue     = 1'b1;
                    addr_next = avm_address + 1'b1;
                end
            end
            DRAIN: begin
                if (sr_valid == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            exp_q          <= '0;
            sr_valid       <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            state          <= state_next;
            avm_chipselect <= issue;
            avm_write      <= issue_wr;
            avm_address    <= addr_next;
            avm_writedata  <= issue_wr ? pattern : 32'h0;
            exp_q          <= pattern;

            // a read on the bus this cycle enters the compare pipeline
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_exp[i]   <= sr_exp[i-1];
                sr_addr[i]  <= sr_addr[i-1];
            end
            sr_valid[0] <= avm_chipselect && !avm_write;
            sr_exp[0]   <= exp_q;
            sr_addr[0]  <= avm_address;

            if (clear) begin
                err_count      <= '0;
                first_err_addr <= '0;
            end else if (cmp_miss) begin
                if (err_count != {ERR_W{1'b1}}) begin
                    err_count <= err_count + 1'b1;
                end
                if (err_count == '0) begin
                    first_err_addr <= sr_addr[READ_LATENCY-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_final_project_soc_onchip_mem_tester.sv
// tb/tb_final_project_soc_onchip_mem_tester.sv - randomized self-check of two tester instances against a behavioural memory/reference
module tb_final_project_soc_onchip_mem_tester;

    localparam logic [31:0] SEED  = 32'hA5A5_0000;
    localparam int          DEPTH = 4;
    localparam int          LAT    [2] = '{1, 3};
    localparam int          ERRMAX [2] = '{255, 3};

    typedef struct packed {
        logic        w;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] c;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        start [2];
    logic        busy  [2];
    logic        done  [2];
    logic        pass  [2];
    logic [7:0]  err_a;
    logic [1:0]  err_b;
    logic [1:0]  ferr  [2];
    logic [1:0]  addr  [2];
    logic [3:0]  be    [2];
    logic        cs    [2];
    logic        wr    [2];
    logic [31:0] wdata [2];
    logic        clken [2];
    logic [31:0] rdata [2];

    logic [31:0] mem     [2][4];
    logic [31:0] corrupt [2][4];
    logic        zero_mode [2];
    logic [31:0] rpipe   [2][3];
    logic [31:0] cyc = 0;
    bus_t        log_q   [2][$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    final_project_soc_onchip_mem_tester #(
        .ADDR_W(2), .READ_LATENCY(1), .SEED(SEED), .ERR_W(8)
    ) u_a (
        .clk(clk), .reset(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err_a), .first_err_addr(ferr[0]),
        .avm_address(addr[0]), .avm_byteenable(be[0]), .avm_chipselect(cs[0]),
        .avm_write(wr[0]), .avm_writedata(wdata[0]), .avm_clken(clken[0]),
        .avm_readdata(rdata[0])
    );

    final_project_soc_onchip_mem_tester #(
        .ADDR_W(2), .READ_LATENCY(3), .SEED(SEED), .ERR_W(2)
    ) u_b (
        .clk(clk), .reset(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err_b), .first_err_addr(ferr[1]),
        .avm_address(addr[1]), .avm_byteenable(be[1]), .avm_chipselect(cs[1]),
        .avm_write(wr[1]), .avm_writedata(wdata[1]), .avm_clken(clken[1]),
        .avm_readdata(rdata[1])
    );

    // memory slave: registered read data, extra stages model longer latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (cs[k] && wr[k]) mem[k][addr[k]] <= wdata[k];
            rpipe[k][0] <= zero_mode[k] ? 32'h0 : (mem[k][addr[k]] ^ corrupt[k][addr[k]]);
            rpipe[k][1] <= rpipe[k][0];
            rpipe[k][2] <= rpipe[k][1];
        end
    end
    assign rdata[0] = rpipe[0][0];
    assign rdata[1] = rpipe[1][2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++)
            if (cs[k]) log_q[k].push_back('{wr[k], addr[k], wdata[k], cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_pat(input int a);
`ifdef FINAL_PROJECT_SOC_MEM_TESTER_LFSR_EN
        logic [31:0] x;
        x = (SEED == 32'h0) ? 32'h1 : SEED;
        for (int i = 0; i < a; i++) x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
        return x;
`else
        return SEED ^ (32'(a) * 32'h0101_0101);
`endif
    endfunction

    function automatic logic [31:0] get_err(input int k);
        return (k == 0) ? 32'(err_a) : 32'(err_b);
    endfunction

    task automatic run_test(input int k, input int mode, input bit poke);
        int nerr, first, t0, tdone;
        bit mis;
        zero_mode[k] = (mode == 3);
        for (int a = 0; a < DEPTH; a++) corrupt[k][a] = 32'h0;
        case (mode)
            1: corrupt[k][$urandom_range(0, 3)] = 32'h1 << $urandom_range(0, 31);
            2: for (int a = 0; a < DEPTH; a++)
                   if ($urandom_range(0, 1) == 1) corrupt[k][a] = $urandom | 32'h1;
            4: corrupt[k][2] = 32'h1;
            default: ;
        endcase
        nerr = 0;
        first = 0;
        for (int a = 0; a < DEPTH; a++) begin
            mis = zero_mode[k] ? (ref_pat(a) != 0) : (corrupt[k][a] != 0);
            if (mis) begin
                if (nerr == 0) first = a;
                nerr++;
            end
        end
        @(negedge clk);
        log_q[k].delete();
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        t0 = int'(cyc);
        check("busy_on_start", 32'(busy[k]), 1);
        check("start_clears_err", get_err(k), 0);
        check("start_clears_first", 32'(ferr[k]), 0);
        check("start_clears_pass", 32'(pass[k]), 0);
        tdone = -1;
        for (int i = 0; i < 40 && tdone < 0; i++) begin
            @(negedge clk);
            start[k] = poke && (int'(cyc) == t0 + DEPTH + 1);
            if (done[k]) tdone = int'(cyc);
        end
        start[k] = 1'b0;
        check("done_latency", 32'(tdone - t0), 32'(2 * DEPTH + LAT[k] + 1));
        check("busy_after_done", 32'(busy[k]), 0);
        check("pass", 32'(pass[k]), 32'(nerr == 0));
        check("err_count", get_err(k), 32'((nerr > ERRMAX[k]) ? ERRMAX[k] : nerr));
        check("first_err_addr", 32'(ferr[k]), 32'(first));
        check("bus_cycles", 32'(log_q[k].size()), 2 * DEPTH);
        for (int i = 0; i < log_q[k].size() && i < 2 * DEPTH; i++) begin
            check("bus_is_write", 32'(log_q[k][i].w), 32'(i < DEPTH));
            check("bus_addr", 32'(log_q[k][i].a), 32'(i % DEPTH));
            check("bus_cycle", log_q[k][i].c - 32'(t0), 32'(i));
            if (i < DEPTH) check("write_data", log_q[k][i].d, ref_pat(i));
        end
    endtask

    initial begin
        int t0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            start[k] = 1'b0;
            zero_mode[k] = 1'b0;
            for (int a = 0; a < DEPTH; a++) corrupt[k][a] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", 32'(busy[k]), 0);
            check("rst_done", 32'(done[k]), 0);
            check("rst_pass", 32'(pass[k]), 0);
            check("rst_err", get_err(k), 0);
            check("rst_first", 32'(ferr[k]), 0);
            check("rst_cs", 32'(cs[k]), 0);
            check("rst_write", 32'(wr[k]), 0);
            check("rst_addr", 32'(addr[k]), 0);
            check("rst_wdata", wdata[k], 0);
            check("byteenable", 32'(be[k]), 32'hF);
            check("clken", 32'(clken[k]), 1);
            rst[k] = 1'b0;
        end

        run_test(0, 0, 1'b0);
        run_test(0, 4, 1'b0);
        run_test(1, 3, 1'b0);
        run_test(1, 0, 1'b1);

        // reset sampled on the second write cycle
        @(negedge clk);
        log_q[0].delete();
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("midrst_cs", 32'(cs[0]), 0);
        check("midrst_busy", 32'(busy[0]), 0);
        check("midrst_done", 32'(done[0]), 0);
        repeat (6) @(negedge clk);
        check("midrst_bus_cycles", 32'(log_q[0].size()), 2);
        run_test(0, 0, 1'b0);

        // start and reset together from DONE
        @(negedge clk);
        t0 = int'(cyc);
        rst[1] = 1'b1;
        start[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        start[1] = 1'b0;
        check("rst_beats_start_busy", 32'(busy[1]), 0);
        check("rst_beats_start_cs", 32'(cs[1]), 0);
        check("rst_beats_start_done", 32'(done[1]), 0);

        for (int it = 0; it < 14; it++)
            run_test(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/final_project_soc_onchip_mem_tester.md
Name: final_project_soc_onchip_mem_tester

Overview:
- Avalon-MM initiator that drives the on-chip memory slave port (32-bit data, 4-bit byteenable, fixed read latency, no waitrequest).
- On a start pulse it fills every word with a deterministic pattern, then reads every word back and compares it with the expected value.
- It reports pass/fail, a saturating error count and the first failing address.
- It sits between a CPU-visible control PIO and the memory's s1 port and serves as a power-on and debug self-test.

Parameters:
- ADDR_W, 2, word address width; DEPTH = 2**ADDR_W words are tested.
- READ_LATENCY, 1, cycles from a read issue (chipselect with write=0) to valid avm_readdata; legal range 1..4.
- SEED, 32'hA5A5_0000, pattern seed.
- ERR_W, 8, width of err_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a test; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done rises.
- done  out  1  level; high in DONE state.
- pass  out  1  valid when done; 1 means zero mismatches.
- err_count  out  ERR_W  number of mismatching words; saturates at all-ones.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.
- avm_address  out  ADDR_W  word address.
- avm_byteenable  out  4  constant 4'hF.
- avm_chipselect  out  1  high on every write or read issue cycle.
- avm_write  out  1  high on write cycles.
- avm_writedata  out  32  write data.
- avm_clken  out  1  constant 1.
- avm_readdata  in  32  read data from memory.

Behaviour:
- Reset: state=IDLE. busy, done, pass, err_count, first_err_addr, avm_chipselect, avm_write, avm_address and avm_writedata are all 0.
- Reset mid-test aborts at the next edge with no further bus cycles. Any pending read pipeline contents are discarded.
- All Avalon outputs are registered.
- States:
  - IDLE: start=1 -> WRITE; clear counters, done, pass, err_count and first_err_addr.
  - WRITE: one write per cycle, address 0..DEPTH-1 ascending. After address DEPTH-1 -> READ.
  - READ: one read issue per cycle, address 0..DEPTH-1. The expected value and address travel down a READ_LATENCY-deep valid/expected/address shift register. After address DEPTH-1 -> DRAIN.
  - DRAIN: wait until the shift register is empty -> DONE.
  - DONE: done=1 and pass=(err_count==0). start=1 -> WRITE, as from IDLE.
- Comparison: when a shift-register stage exits with valid=1, compare avm_readdata against the expected value.
  - On mismatch, err_count increments, saturating at 2**ERR_W-1.
  - If it is the first mismatch, first_err_addr captures the address.
- Pattern (default): pattern(a) = SEED ^ (zero-extended a * 32'h0101_0101), truncated to 32 bits.
- Timing, with start sampled high at edge T:
  - write cycles on edges T+1..T+DEPTH;
  - read issue cycles on edges T+DEPTH+1..T+2*DEPTH;
  - last compare at T+2*DEPTH+READ_LATENCY;
  - done=1 from T+2*DEPTH+READ_LATENCY+1.
- Boundary conditions:
  - start while busy: ignored, no effect.
  - start and reset in the same cycle: reset wins.
  - The address counter wraps only at phase change, never mid-phase.
  - A new start from DONE clears the previous results in the cycle busy rises.

Optional Feature:
- Macro: FINAL_PROJECT_SOC_MEM_TESTER_LFSR_EN.
- When defined, the pattern is a 32-bit Galois LFSR with taps 32'h8020_0003. It is loaded with SEED (or 32'h1 if SEED==0) at the start of both WRITE and READ, and advances once per issued word. Expected values are still carried through the shift register.
- When undefined, the address-XOR pattern above is used and no LFSR flops exist.

Decomposition:
- Package final_project_soc_mem_tester_pkg holds:
  - the state enum (IDLE, WRITE, READ, DRAIN, DONE);
  - the LFSR_TAPS constant;
  - the MULT constant 32'h0101_0101;
  - the pattern function for the non-LFSR mode.
- Sub-module final_project_soc_mem_tester_patgen has inputs restart, advance and addr, and output pattern. It hides the macro selection. One instance serves both phases.

Test Plan:
- Ideal memory model, DEPTH=4, L=1, SEED=A5A50000:
  - writes A5A50000, A4A40101, A7A70202 and A6A60303 to addresses 0..3;
  - done at T+10, pass=1, err_count=0.
- Model flips bit 0 of address 2 on read -> pass=0, err_count=1, first_err_addr=2.
- Model returns 0 for all reads, ERR_W=2 -> err_count=3 (saturated), first_err_addr=0.
- Reset asserted on the second write cycle -> next cycle chipselect=0, busy=0, done=0. A subsequent start runs a clean test and passes.
- start pulsed during READ -> ignored, single test completes at the normal cycle. READ_LATENCY=3 -> done at T+12, pass=1.
- With the LFSR macro defined -> write data is LFSR steps 0..3 from SEED, readback matches, pass=1.
